// File: rtl/led_serial_driver.sv
// Self-timed serial LED chain driver: snapshots a WIDTH-bit bitmap on a refresh tick
// or an update request and shifts it out on led_do/led_clk, with coalesced re-triggers.
module led_serial_driver #(
    parameter int WIDTH          = 16,
    parameter int SCLK_HALF      = 2,
    parameter int REFRESH_PERIOD = 524288,
    parameter int MSB_FIRST      = 1,
    parameter int INVERT         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bitmap,
    input  logic             enable,
    input  logic             update,
    output logic             led_clk,
    output logic             led_do,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PH_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(SCLK_HALF - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0] r_bit_idx, w_bit_idx_next;
    logic [PH_W-1:0]  r_phase, w_phase_next;
    logic             r_pending, w_pending_next;
    logic             r_led_clk, r_led_do, r_busy, r_done;
    logic             w_led_clk_next, w_led_do_next, w_busy_next, w_done_next;
    logic             w_tick, w_trig;

    generate
        if (REFRESH_PERIOD > 0) begin : g_refresh
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_PERIOD - 1);
            logic [CNT_W-1:0] r_refresh_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_refresh_cnt <= '0;
                else if (!enable || r_refresh_cnt == LAST_CNT)
                    r_refresh_cnt <= '0;
                else
                    r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            end

            assign w_tick = enable && (r_refresh_cnt == LAST_CNT);
        end else begin : g_no_refresh
            assign w_tick = 1'b0;
        end
    endgenerate

    assign w_trig = w_tick | update;

    // The bit being presented always sits at one fixed end of the shift register.
    function automatic logic cur_bit(input logic [WIDTH-1:0] s);
        return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        return (MSB_FIRST != 0) ? (s << 1) : (s >> 1);
    endfunction

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_phase_next   = r_phase;
        w_pending_next = r_pending;
        case (r_state)
            IDLE: begin
                if (w_trig || r_pending) begin
                    w_state_next   = SHIFT_LO;
                    w_shift_next   = bitmap;
                    w_bit_idx_next = '0;
                    w_phase_next   = '0;
                    w_pending_next = 1'b0;
                end
            end
            SHIFT_LO: begin
                if (w_trig) w_pending_next = 1'b1;
                if (r_phase == LAST_PH) begin
                    w_phase_next = '0;
                    w_state_next = SHIFT_HI;
                end else begin
                    w_phase_next = r_phase + PH_W'(1);
                end
            end
            SHIFT_HI: begin
                if (w_trig) w_pending_next = 1'b1;
                if (r_phase == LAST_PH) begin
                    w_phase_next = '0;
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                        w_shift_next   = advance(r_shift);
                        w_state_next   = SHIFT_LO;
                    end
                end else begin
                    w_phase_next = r_phase + PH_W'(1);
                end
            end
            DONE: begin
                // A trigger landing here re-arms pending even as the old one is consumed.
                w_pending_next = w_trig;
                if (r_pending) begin
                    w_state_next   = SHIFT_LO;
                    w_shift_next   = bitmap;
                    w_bit_idx_next = '0;
                    w_phase_next   = '0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_busy_next    = (w_state_next == SHIFT_LO) || (w_state_next == SHIFT_HI);
        w_done_next    = (w_state_next == DONE);
        w_led_clk_next = (w_state_next != SHIFT_LO);
        w_led_do_next  = w_busy_next ? (cur_bit(w_shift_next) ^ (INVERT != 0)) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_phase   <= '0;
            r_pending <= 1'b0;
            r_led_clk <= 1'b1;
            r_led_do  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_phase   <= w_phase_next;
            r_pending <= w_pending_next;
            r_led_clk <= w_led_clk_next;
            r_led_do  <= w_led_do_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign led_clk = r_led_clk;
    assign led_do  = r_led_do;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_led_serial_driver.sv
// Bench for led_serial_driver: three configurations, frames captured from the pins
// and compared with bit sequences derived from the bitmap, bit order and polarity.
module tb_led_serial_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] bm_a = '0, bm_b = '0;
    logic [3:0] bm_c = '0;
    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic       upd_a = 1'b0, upd_b = 1'b0, upd_c = 1'b0;
    logic [2:0] lc, ld, bz, dn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_serial_driver #(.WIDTH(8), .SCLK_HALF(2), .REFRESH_PERIOD(0), .MSB_FIRST(1), .INVERT(0)) u_a (
        .clk(clk), .rst(rst), .bitmap(bm_a), .enable(en_a), .update(upd_a),
        .led_clk(lc[0]), .led_do(ld[0]), .busy(bz[0]), .done(dn[0]));
    led_serial_driver #(.WIDTH(8), .SCLK_HALF(3), .REFRESH_PERIOD(0), .MSB_FIRST(0), .INVERT(1)) u_b (
        .clk(clk), .rst(rst), .bitmap(bm_b), .enable(en_b), .update(upd_b),
        .led_clk(lc[1]), .led_do(ld[1]), .busy(bz[1]), .done(dn[1]));
    led_serial_driver #(.WIDTH(4), .SCLK_HALF(1), .REFRESH_PERIOD(100), .MSB_FIRST(1), .INVERT(0)) u_c (
        .clk(clk), .rst(rst), .bitmap(bm_c), .enable(en_c), .update(upd_c),
        .led_clk(lc[2]), .led_do(ld[2]), .busy(bz[2]), .done(dn[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sh_of(input int k);
        case (k)
            0: return 2;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    // Sequence as the chain would receive it; the first bit sent ends up most significant.
    function automatic logic [31:0] exp_seq(input logic [31:0] bm, input int w, input bit msb, input bit inv);
        logic [31:0] r = '0;
        logic b;
        for (int i = 0; i < w; i++) begin
            b = msb ? bm[w-1-i] : bm[i];
            r = {r[30:0], b ^ inv};
        end
        return r;
    endfunction

    // Pin monitor: sampled on the falling clk edge, records every completed frame.
    int          cyc = 0;
    int          fr_n[3];
    logic [31:0] fr_bits[3][16];
    int          fr_nb[3][16], fr_busy[3][16], fr_start[3][16], fr_done[3][16];
    logic [31:0] cur_bits[3];
    int          cur_nb[3], cur_busy[3], cur_start[3], run_len[3];
    int          rise_cnt[3], viol_phase[3], viol_data[3];
    logic [2:0]  p_lc = '1, p_ld = '0, p_bz = '0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            fr_n[k] = 0; cur_bits[k] = '0; cur_nb[k] = 0; cur_busy[k] = 0; cur_start[k] = 0;
            run_len[k] = 0; rise_cnt[k] = 0; viol_phase[k] = 0; viol_data[k] = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                if (bz[k] && !p_bz[k]) begin
                    cur_bits[k] = '0; cur_nb[k] = 0; cur_busy[k] = 0; cur_start[k] = cyc;
                end
                if (bz[k]) cur_busy[k]++;
                if (lc[k] && !p_lc[k]) begin
                    cur_bits[k] = {cur_bits[k][30:0], ld[k]};
                    cur_nb[k]++;
                    rise_cnt[k]++;
                end
                if (p_bz[k]) begin
                    if (bz[k] && lc[k] == p_lc[k]) run_len[k]++;
                    else begin
                        if (run_len[k] != sh_of(k)) viol_phase[k]++;
                        run_len[k] = 1;
                    end
                    if (bz[k] && ld[k] != p_ld[k] && !(p_lc[k] && !lc[k])) viol_data[k]++;
                end else begin
                    run_len[k] = 1;
                end
                if (dn[k] && fr_n[k] < 16) begin
                    fr_bits[k][fr_n[k]]  = cur_bits[k];
                    fr_nb[k][fr_n[k]]    = cur_nb[k];
                    fr_busy[k][fr_n[k]]  = cur_busy[k];
                    fr_start[k][fr_n[k]] = cur_start[k];
                    fr_done[k][fr_n[k]]  = cyc;
                    fr_n[k]++;
                end
            end else begin
                run_len[k] = 0;
            end
            p_lc[k] = lc[k]; p_ld[k] = ld[k]; p_bz[k] = bz[k];
        end
    end

    task automatic pulse(input int k);
        @(posedge clk); #1;
        case (k) 0: upd_a = 1'b1; 1: upd_b = 1'b1; default: upd_c = 1'b1; endcase
        @(posedge clk); #1;
        upd_a = 1'b0; upd_b = 1'b0; upd_c = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int n, input int budget, input string tag);
        int i = 0;
        while (fr_n[k] < n && i < budget) begin
            @(posedge clk);
            i++;
        end
        check(tag, fr_n[k], n);
    endtask

    task automatic check_frame(input int k, input int idx, input logic [31:0] bm, input int w,
                               input bit msb, input bit inv, input string tag);
        int len = w * 2 * sh_of(k);
        check({tag, "_bits"}, fr_bits[k][idx], exp_seq(bm, w, msb, inv));
        check({tag, "_rises"}, fr_nb[k][idx], w);
        check({tag, "_busy"}, fr_busy[k][idx], len);
        check({tag, "_done_at"}, fr_done[k][idx] - fr_start[k][idx], len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  old;
        int          n, rc, i;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_lc%0d", k), lc[k], 1'b1);
            check($sformatf("rst_do%0d", k), ld[k], 1'b0);
            check($sformatf("rst_busy%0d", k), bz[k], 1'b0);
            check($sformatf("rst_done%0d", k), dn[k], 1'b0);
        end
        @(posedge clk); #1 rst = 1'b1;

        // Single frame, MSB first
        bm_a = 8'hA5;
        pulse(0);
        wait_frames(0, 1, 200, "a_frame1");
        check_frame(0, 0, 32'hA5, 8, 1, 0, "a_A5");

        for (int r = 0; r < 4; r++) begin
            v = $urandom;
            bm_a = v[7:0];
            n = fr_n[0];
            pulse(0);
            wait_frames(0, n + 1, 200, "a_rand_wait");
            check_frame(0, n, {24'h0, v[7:0]}, 8, 1, 0, $sformatf("a_rand%0d", r));
        end

        // Snapshot and coalescing of several triggers during a frame
        v = $urandom_range(0, 254);
        old = v[7:0];
        bm_a = old;
        n = fr_n[0];
        pulse(0);
        i = 0;
        while (!bz[0] && i < 10) begin @(negedge clk); i++; end
        check("a_busy_seen", bz[0], 1'b1);
        repeat (3) @(posedge clk);
        #1 bm_a = 8'hFF;
        pulse(0);
        repeat (2) @(posedge clk);
        pulse(0);
        repeat (2) @(posedge clk);
        pulse(0);
        wait_frames(0, n + 2, 300, "a_coal_wait");
        check_frame(0, n, {24'h0, old}, 8, 1, 0, "a_snap_old");
        check_frame(0, n + 1, 32'hFF, 8, 1, 0, "a_snap_ff");
        check("a_back_to_back", fr_start[0][n+1], fr_done[0][n] + 1);
        repeat (80) @(posedge clk);
        check("a_no_extra", fr_n[0], n + 2);

        // LSB first with inverted data, slower serial clock
        bm_b = 8'h01;
        pulse(1);
        wait_frames(1, 1, 300, "b_frame1");
        check_frame(1, 0, 32'h01, 8, 0, 1, "b_01");
        check("b_01_literal", fr_bits[1][0], 32'h7F);
        for (int r = 0; r < 3; r++) begin
            v = $urandom;
            bm_b = v[7:0];
            n = fr_n[1];
            pulse(1);
            wait_frames(1, n + 1, 300, "b_rand_wait");
            check_frame(1, n, {24'h0, v[7:0]}, 8, 0, 1, $sformatf("b_rand%0d", r));
        end

        // Auto refresh every 100 cycles, then disabled but still updatable
        v = $urandom;
        bm_c = v[3:0];
        n = fr_n[2];
        @(posedge clk); #1 en_c = 1'b1;
        wait_frames(2, n + 3, 400, "c_auto_wait");
        #1 en_c = 1'b0;
        check_frame(2, n, {28'h0, v[3:0]}, 4, 1, 0, "c_auto");
        check("c_period1", fr_start[2][n+1] - fr_start[2][n], 100);
        check("c_period2", fr_start[2][n+2] - fr_start[2][n+1], 100);
        repeat (250) @(posedge clk);
        check("c_disabled", fr_n[2], n + 3);
        pulse(2);
        wait_frames(2, n + 4, 50, "c_update_wait");
        check_frame(2, n + 3, {28'h0, v[3:0]}, 4, 1, 0, "c_upd");

        // Asynchronous reset in the middle of a frame
        bm_a = 8'hFF;
        rc = rise_cnt[0];
        pulse(0);
        i = 0;
        while (rise_cnt[0] < rc + 3 && i < 100) begin @(negedge clk); i++; end
        while (lc[0] && i < 100) begin @(negedge clk); i++; end
        check("a_mid_busy", bz[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        check("a_async_lc", lc[0], 1'b1);
        check("a_async_do", ld[0], 1'b0);
        check("a_async_busy", bz[0], 1'b0);
        check("a_async_done", dn[0], 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        rc = rise_cnt[0];
        n = fr_n[0];
        repeat (40) @(posedge clk);
        check("a_quiet_rises", rise_cnt[0], rc);
        check("a_quiet_frames", fr_n[0], n);
        v = $urandom;
        bm_a = v[7:0];
        pulse(0);
        wait_frames(0, n + 1, 200, "a_post_rst_wait");
        check_frame(0, n, {24'h0, v[7:0]}, 8, 1, 0, "a_post_rst");

        for (int k = 0; k < 3; k++) begin
            check($sformatf("phase_len%0d", k), viol_phase[k], 0);
            check($sformatf("data_edge%0d", k), viol_data[k], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
